// File: rtl/mips_datapath_register_scoreboard_file.sv
// Register file with a per-register load scoreboard.
// Each read port returns zero-latency data plus a busy flag for its source.
// The top-level stall is the OR of busy flags over the ports whose operand is in use.
// Optional write-back forwarding is enabled by defining MIPS_DATAPATH_REGISTER_BYPASS_EN.
// Register 0 always reads as zero. It can never become busy.
module mips_datapath_register_scoreboard_file #(
  parameter int WIDTH      = 32,
  parameter int ADDR_W     = 5,
  parameter int READ_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [READ_PORTS*ADDR_W-1:0] rd_addr,
  input  logic [READ_PORTS-1:0]        rd_use,
  input  logic                         wr_enable,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         wr_load,
  input  logic                         issue_enable,
  input  logic [ADDR_W-1:0]            issue_addr,
  output logic [READ_PORTS*WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]        rd_busy,
  output logic                         stall,
  output logic                         port_eq,
  output logic [ADDR_W:0]              pending
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_valid;
  logic             clr_valid;
  logic             iss_valid;
  logic             inc;
  logic             dec;

  assign wr_valid  = wr_enable && (wr_addr != '0);
  assign clr_valid = wr_valid && wr_load;
  assign iss_valid = issue_enable && (issue_addr != '0);

  // Next busy vector: clear first, then set, so an issue wins over a load-clear to the same register.
  always_comb begin
    busy_nxt = busy;
    if (clr_valid) busy_nxt[wr_addr] = 1'b0;
    if (iss_valid) busy_nxt[issue_addr] = 1'b1;
  end

  // Net change of the busy count. Redundant issues and clears of idle registers do not count.
  always_comb begin
    inc = iss_valid && !busy[issue_addr];
    dec = clr_valid && busy[wr_addr] && !(iss_valid && (issue_addr == wr_addr));
  end

  // Register storage, scoreboard and busy count. Reset overrides any same-cycle activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy    <= '0;
      pending <= '0;
    end else begin
      if (wr_valid) regs[wr_addr] <= wr_data;
      busy    <= busy_nxt;
      pending <= pending + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  stored;
    assign a      = rd_addr[k*ADDR_W +: ADDR_W];
    assign stored = (a == '0) ? '0 : regs[a];
`ifdef MIPS_DATAPATH_REGISTER_BYPASS_EN
    logic hit;
    assign hit = wr_valid && (a == wr_addr);
    assign rd_data[k*WIDTH +: WIDTH] = hit ? wr_data : stored;
    assign rd_busy[k] = (hit && wr_load && !(iss_valid && (issue_addr == wr_addr))) ? 1'b0 : busy[a];
`else
    assign rd_data[k*WIDTH +: WIDTH] = stored;
    assign rd_busy[k] = busy[a];
`endif
  end

  assign stall = |(rd_use & rd_busy);

  if (READ_PORTS >= 2) begin : g_eq
    assign port_eq = (rd_data[0 +: WIDTH] == rd_data[WIDTH +: WIDTH]);
  end else begin : g_no_eq
    assign port_eq = 1'b0;
  end

endmodule

// File: tb/tb_mips_datapath_register_scoreboard_file.sv
// Directed bench for the register/scoreboard file.
// Expected values are queued as each step is driven, then popped and compared when the outputs are sampled.
// It covers both builds, with and without MIPS_DATAPATH_REGISTER_BYPASS_EN.
module tb_mips_datapath_register_scoreboard_file;

  localparam int WIDTH = 32;
  localparam int ADDR_W = 5;
  localparam int RP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [RP*ADDR_W-1:0] rd_addr;
  logic [RP-1:0]    rd_use;
  logic             wr_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_load;
  logic             issue_enable;
  logic [ADDR_W-1:0] issue_addr;
  logic [RP*WIDTH-1:0] rd_data;
  logic [RP-1:0]    rd_busy;
  logic             stall;
  logic             port_eq;
  logic [ADDR_W:0]  pending;

  mips_datapath_register_scoreboard_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .READ_PORTS(RP)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_load(wr_load),
    .issue_enable(issue_enable), .issue_addr(issue_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall), .port_eq(port_eq), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef enum int {S_DATA, S_DATA0, S_DATA1, S_BUSY, S_BUSY0, S_BUSY1, S_STALL, S_EQ, S_PEND} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] observe(sel_t s);
    case (s)
      S_DATA:  return 64'(rd_data);
      S_DATA0: return 64'(rd_data[0 +: WIDTH]);
      S_DATA1: return 64'(rd_data[WIDTH +: WIDTH]);
      S_BUSY:  return 64'(rd_busy);
      S_BUSY0: return 64'(rd_busy[0]);
      S_BUSY1: return 64'(rd_busy[1]);
      S_STALL: return 64'(stall);
      S_EQ:    return 64'(port_eq);
      default: return 64'(pending);
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_t sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_enable = 1'b0;
    wr_load = 1'b0;
    issue_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    rd_use = '0;
    wr_enable = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_load = 1'b0;
    issue_enable = 1'b0;
    issue_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    expect_val("reset_data", S_DATA, 64'h0);
    expect_val("reset_busy", S_BUSY, 64'h0);
    expect_val("reset_stall", S_STALL, 64'h0);
    expect_val("reset_eq", S_EQ, 64'h1);
    expect_val("reset_pending", S_PEND, 64'h0);
    check_all();

    // write r5 and read it back on port 0
    wr_enable = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234ABCD;
    tick();
    idle();
    rd_addr[0 +: ADDR_W] = 5'd5;
    #1;
    expect_val("r5_data", S_DATA0, 64'h1234ABCD);
    expect_val("r5_busy", S_BUSY0, 64'h0);
    expect_val("r5_vs_r0_eq", S_EQ, 64'h0);
    check_all();

    // r0 ignores writes and issues
    wr_enable = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    tick();
    idle();
    rd_addr[0 +: ADDR_W] = 5'd0;
    issue_enable = 1'b1; issue_addr = 5'd0;
    tick();
    idle();
    expect_val("r0_data", S_DATA0, 64'h0);
    expect_val("r0_issue_pending", S_PEND, 64'h0);
    expect_val("r0_busy", S_BUSY0, 64'h0);
    check_all();

    // load to r3 outstanding, then completed
    issue_enable = 1'b1; issue_addr = 5'd3;
    tick();
    idle();
    rd_addr[ADDR_W +: ADDR_W] = 5'd3;
    rd_use = 2'b10;
    #1;
    expect_val("r3_busy1", S_BUSY1, 64'h1);
    expect_val("r3_stall", S_STALL, 64'h1);
    expect_val("r3_pending", S_PEND, 64'h1);
    check_all();
    wr_enable = 1'b1; wr_load = 1'b1; wr_addr = 5'd3; wr_data = 32'h77;
    tick();
    idle();
    expect_val("r3_wb_stall", S_STALL, 64'h0);
    expect_val("r3_wb_pending", S_PEND, 64'h0);
    expect_val("r3_wb_data1", S_DATA1, 64'h77);
    expect_val("r3_wb_busy1", S_BUSY1, 64'h0);
    check_all();

    // issue beats load-clear on the same register
    issue_enable = 1'b1; issue_addr = 5'd4;
    tick();
    issue_enable = 1'b1; issue_addr = 5'd4;
    wr_enable = 1'b1; wr_load = 1'b1; wr_addr = 5'd4; wr_data = 32'h99;
    tick();
    idle();
    rd_addr[0 +: ADDR_W] = 5'd4;
    #1;
    expect_val("r4_set_prio_busy", S_BUSY0, 64'h1);
    expect_val("r4_set_prio_pending", S_PEND, 64'h1);
    expect_val("r4_data", S_DATA0, 64'h99);
    check_all();

    // redundant issue and clear of an idle register do not move the count
    issue_enable = 1'b1; issue_addr = 5'd4;
    tick();
    idle();
    wr_enable = 1'b1; wr_load = 1'b1; wr_addr = 5'd6; wr_data = 32'h6;
    tick();
    idle();
    expect_val("dup_issue_idle_clear_pending", S_PEND, 64'h1);
    check_all();
    wr_enable = 1'b1; wr_load = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    tick();
    idle();
    expect_val("r4_clear_pending", S_PEND, 64'h0);
    expect_val("r4_clear_busy", S_BUSY0, 64'h0);
    check_all();

    // write-back in flight to a busy r3 read on both ports
    issue_enable = 1'b1; issue_addr = 5'd3;
    tick();
    idle();
    rd_addr = {5'd3, 5'd3};
    rd_use = 2'b01;
    wr_enable = 1'b1; wr_load = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    #1;
`ifdef MIPS_DATAPATH_REGISTER_BYPASS_EN
    expect_val("bypass_data0", S_DATA0, 64'h55);
    expect_val("bypass_busy0", S_BUSY0, 64'h0);
    expect_val("bypass_stall", S_STALL, 64'h0);
`else
    expect_val("nobypass_data0", S_DATA0, 64'h77);
    expect_val("nobypass_busy0", S_BUSY0, 64'h1);
    expect_val("nobypass_stall", S_STALL, 64'h1);
`endif
    expect_val("same_src_eq", S_EQ, 64'h1);
    check_all();
    tick();
    idle();
    expect_val("r3_after_wb_data0", S_DATA0, 64'h55);
    expect_val("r3_after_wb_stall", S_STALL, 64'h0);
    expect_val("r3_after_wb_pending", S_PEND, 64'h0);
    check_all();

    // reset overrides pending loads and a simultaneous write
    issue_enable = 1'b1; issue_addr = 5'd1;
    tick();
    issue_enable = 1'b1; issue_addr = 5'd2;
    tick();
    idle();
    expect_val("two_loads_pending", S_PEND, 64'h2);
    check_all();
    rst = 1'b1;
    wr_enable = 1'b1; wr_load = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD;
    issue_enable = 1'b1; issue_addr = 5'd9;
    tick();
    rst = 1'b0;
    idle();
    rd_addr = {5'd1, 5'd7};
    rd_use = 2'b11;
    #1;
    expect_val("rst2_data", S_DATA, 64'h0);
    expect_val("rst2_busy", S_BUSY, 64'h0);
    expect_val("rst2_stall", S_STALL, 64'h0);
    expect_val("rst2_eq", S_EQ, 64'h1);
    expect_val("rst2_pending", S_PEND, 64'h0);
    check_all();
    rd_addr = {5'd9, 5'd5};
    #1;
    expect_val("rst2_r5_cleared", S_DATA0, 64'h0);
    expect_val("rst2_r9_idle", S_BUSY1, 64'h0);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
